rsa_modexp_unit: RTL

Modular-exponentiation engine computing c = m^e mod p, using bit-serial Montgomery multiplication with R = 2^WIDTH.
- Sits directly downstream of the SPI register bank.
- Consumes its P/E/M/Const registers and start/stop command pulses.
- Returns the result plus a one-cycle end-of-computation pulse, which the bank captures into its C register and reports in status bit 0.

---
 rtl/rsa_modexp_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation c = m^e mod p using bit-serial Montgomery products, R = 2^WIDTH.
// Optional: RSA_MODEXP_CONST_TIME_EN runs a multiply for every exponent bit (fixed latency).
module rsa_modexp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start_cmd,
    input  logic             stop_cmd,
    input  logic [WIDTH-1:0] rsa_p,
    input  logic [WIDTH-1:0] rsa_e,
    input  logic [WIDTH-1:0] rsa_m,
    input  logic [WIDTH-1:0] rsa_const,
    output logic [WIDTH-1:0] rsa_c,
    output logic             eoc,
    output logic             busy
);

    localparam int UW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, MP_X, MP_ONE, SQUARE, MULT, FINAL, DONE
    } state_t;

    state_t          state_reg;
    logic [WIDTH-1:0] p_reg, e_reg, m_reg, const_reg;
    logic [WIDTH-1:0] xbar_reg, a_reg;
    logic [UW-1:0]    u_reg;
    logic [CW-1:0]    cnt_reg;
    logic [IW-1:0]    bit_idx_reg;
`ifdef RSA_MODEXP_CONST_TIME_EN
    logic [WIDTH-1:0] dummy_reg;
`endif

    logic [WIDTH-1:0] op_a, op_b;
    logic [UW-1:0]    p_ext, u_add, u_odd, u_step;
    logic [WIDTH-1:0] mp_res;
    logic             mp_last, e_bit;

    // Operands of the Montgomery product depend only on which phase is running.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_reg)
            MP_X:    begin op_a = m_reg;     op_b = const_reg; end
            MP_ONE:  begin op_a = const_reg; op_b = WIDTH'(1); end
            SQUARE:  begin op_a = a_reg;     op_b = a_reg;     end
            MULT:    begin op_a = a_reg;     op_b = xbar_reg;  end
            FINAL:   begin op_a = a_reg;     op_b = WIDTH'(1); end
            default: begin op_a = '0;        op_b = '0;        end
        endcase
    end

    assign p_ext   = {2'b00, p_reg};
    assign u_add   = u_reg + (op_a[cnt_reg[IW-1:0]] ? {2'b00, op_b} : '0);
    assign u_odd   = u_add[0] ? (u_add + p_ext) : u_add;
    assign u_step  = u_odd >> 1;
    assign mp_res  = WIDTH'((u_reg >= p_ext) ? (u_reg - p_ext) : u_reg);
    assign mp_last = (cnt_reg == CW'(WIDTH));
    assign e_bit   = e_reg[bit_idx_reg];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            e_reg       <= '0;
            m_reg       <= '0;
            const_reg   <= '0;
            xbar_reg    <= '0;
            a_reg       <= '0;
            u_reg       <= '0;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
`ifdef RSA_MODEXP_CONST_TIME_EN
            dummy_reg   <= '0;
`endif
            rsa_c       <= '0;
            eoc         <= 1'b0;
            busy        <= 1'b0;
        end else if (ena) begin
            eoc <= 1'b0;
            if (stop_cmd && state_reg != IDLE) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
                u_reg     <= '0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_cmd && !stop_cmd) begin
                            state_reg <= LOAD;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        p_reg       <= rsa_p;
                        e_reg       <= rsa_e;
                        m_reg       <= rsa_m;
                        const_reg   <= rsa_const;
                        bit_idx_reg <= IW'(WIDTH - 1);
                        u_reg       <= '0;
                        cnt_reg     <= '0;
                        if (!rsa_p[0] || rsa_p < WIDTH'(3)) begin
                            rsa_c     <= '0;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= MP_X;
                        end
                    end
                    DONE: begin
                        eoc       <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        if (!mp_last) begin
                            u_reg   <= u_step;
                            cnt_reg <= cnt_reg + CW'(1);
                        end else begin
                            u_reg   <= '0;
                            cnt_reg <= '0;
                            case (state_reg)
                                MP_X: begin
                                    xbar_reg  <= mp_res;
                                    state_reg <= MP_ONE;
                                end
                                MP_ONE: begin
                                    a_reg     <= mp_res;
                                    state_reg <= SQUARE;
                                end
                                SQUARE: begin
                                    a_reg <= mp_res;
`ifdef RSA_MODEXP_CONST_TIME_EN
                                    state_reg <= MULT;
`else
                                    if (e_bit) begin
                                        state_reg <= MULT;
                                    end else if (bit_idx_reg == '0) begin
                                        state_reg <= FINAL;
                                    end else begin
                                        bit_idx_reg <= bit_idx_reg - IW'(1);
                                        state_reg   <= SQUARE;
                                    end
`endif
                                end
                                MULT: begin
`ifdef RSA_MODEXP_CONST_TIME_EN
                                    // Clear exponent bits still pay for a multiply; the product is discarded.
                                    if (e_bit)
                                        a_reg <= mp_res;
                                    else
                                        dummy_reg <= mp_res;
`else
                                    a_reg <= mp_res;
`endif
                                    if (bit_idx_reg == '0) begin
                                        state_reg <= FINAL;
                                    end else begin
                                        bit_idx_reg <= bit_idx_reg - IW'(1);
                                        state_reg   <= SQUARE;
                                    end
                                end
                                FINAL: begin
                                    rsa_c     <= mp_res;
                                    state_reg <= DONE;
                                end
                                default: state_reg <= IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
